axi_burst_resp_channel: RTL and testbench
=========================================

Name: axi_burst_resp_channel

Overview:
- Responder-side counterpart of the memcopy engine's AXI address-send channel. It sits on the slave end of an AR/AW address channel inside the engine's memory model and loopback test path.
- Accepts address handshakes into a small command FIFO, then expands each burst into per-beat addresses with a last flag toward a local data backend.
- Checks every accepted burst for alignment and 4KB-crossing violations, and counts completed bursts.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
FIFO_AW, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
axi_addr  in  64  burst start address
axi_len  in  8  beats minus 1
axi_valid  in  1  address valid
axi_ready  out  1  address ready
size  in  3  beat size code (bytes = 1<<size); static while busy
beat_addr  out  64  current beat byte address
beat_last  out  1  final beat of burst
beat_valid  out  1  beat valid
beat_ready  in  1  backend accepts beat
burst_done  out  1  one-cycle pulse on last-beat handshake
burst_count  out  32  completed bursts, wraps at 2^32
protocol_error  out  1  sticky violation flag
clear_error  in  1  clears protocol_error

Behaviour:
- Reset values: axi_ready=1, beat_addr=0, beat_last=0, beat_valid=0, burst_done=0, burst_count=0, protocol_error=0. FIFO empty, FSM in IDLE.
- Size codes: valid codes are 3'b010..3'b111; any other code is treated as 3'b111.
- Command FIFO:
  - axi_ready = !full (combinational from the occupancy count).
  - Push on axi_valid && axi_ready; stores {addr, len}.
  - Push and pop in the same cycle leave the count unchanged.
  - No push is possible while full.
- FSM, one-hot, states IDLE, LOAD, BEAT:
  - IDLE: FIFO non-empty → pop, go to LOAD.
  - LOAD: latch beat_addr=entry.addr and beats_left=entry.len; go to BEAT.
  - BEAT: beat_valid=1 and beat_last=(beats_left==0).
    - On beat_ready with beats_left≠0: beat_addr += (1<<size), beats_left -= 1.
    - On beat_ready with beats_left==0: burst_done pulses next cycle, burst_count += 1, go to IDLE.
- Latency: with an empty FIFO and an idle FSM, beat_valid rises after the second clock edge following the accepting edge. The gap between bursts is 2 idle cycles.
- Hold rule: beat_addr and beat_last stay stable while beat_valid && !beat_ready.
- Address arithmetic:
  - 64-bit increment with no wrapping at 4KB; crossings are flagged, not corrected.
  - Overflow past 2^64 wraps silently.
- Error checks, evaluated at push time on axi_addr/axi_len:
  - Misalignment: axi_addr & ((1<<size)-1) ≠ 0.
  - 4KB crossing: 17-bit compare of {5'b0, axi_addr[11:0]} + ((axi_len+1)<<size) > 4096.
  - Either condition sets protocol_error. The burst is still fully processed.
  - A set in the same cycle as clear_error wins; the flag stays set.
- Reset mid-burst:
  - All state clears asynchronously and beat_valid drops immediately.
  - In-flight and queued commands are discarded.

Decomposition:
- Shared package (memcopy_pkg):
  - FSM state encodings IDLE/LOAD/BEAT.
  - Size-code constants SIZE_4B..SIZE_128B.
  - Function size_to_bytes(size) returning 8 bits.
  - Constant KB4_BYTES=4096.
- Sub-module axi_cmd_fifo: synchronous FIFO, parameterised by depth and width (72 bits here).
  - Outputs full, empty, dout (show-ahead).
  - Same async active-low reset.

Test Plan:
- Basic burst: size=3'b110, axi_addr=0x1000, axi_len=3, beat_ready=1 → beats at 0x1000, 0x1040, 0x1080, 0x10C0; beat_last only on 0x10C0; burst_done pulses once; burst_count=1; protocol_error=0.
- FIFO full: five back-to-back bursts with beat_ready=0 and FIFO_DEPTH=4 → 4 accepted, axi_ready low. axi_ready returns high one cycle after the first pop; the fifth is then accepted.
- 4KB crossing: axi_addr=0x0FC0, axi_len=1, size=3'b110 → protocol_error=1; beats 0x0FC0 then 0x1000; clear_error pulse → 0.
- Misalignment and priority: axi_addr=0x1008, size=3'b110, axi_len=0 → protocol_error=1, one beat at 0x1008 with beat_last=1. A simultaneous clear_error with a new violating push keeps the flag at 1.
- Backpressure: beat_ready random at ~50%, axi_len=7, size=3'b101 → beat_addr and beat_last stable whenever stalled; 8 beats with 32B stride; exactly one burst_done.
- Reset mid-burst: resetn low at beat 2 of 4 with 2 bursts queued → all outputs at reset values. After release, no beats appear until a new push.

Source files
------------

// File: rtl/memcopy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memcopy_pkg
//  Description : Shared types, constants and helpers for the memcopy engine's
//                AXI address-channel blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package memcopy_pkg;

   // One-hot burst-expansion states
   typedef enum logic [2:0] {
      IDLE = 3'b001,
      LOAD = 3'b010,
      BEAT = 3'b100
   } state_e;

   // AXI beat size codes supported by the responder
   localparam logic [2:0] SIZE_4B   = 3'b010;
   localparam logic [2:0] SIZE_8B   = 3'b011;
   localparam logic [2:0] SIZE_16B  = 3'b100;
   localparam logic [2:0] SIZE_32B  = 3'b101;
   localparam logic [2:0] SIZE_64B  = 3'b110;
   localparam logic [2:0] SIZE_128B = 3'b111;

   // 4KB page size, wide enough for the 17-bit crossing compare
   localparam logic [16:0] KB4_BYTES = 17'd4096;

   // One queued address command
   typedef struct packed {
      logic [63:0] addr;
      logic [7:0]  len;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   // Codes below 4 bytes are not supported and fall back to the widest beat
   function automatic logic [2:0] norm_size(input logic [2:0] size);
      case (size)
         SIZE_4B, SIZE_8B, SIZE_16B,
         SIZE_32B, SIZE_64B, SIZE_128B: return size;
         default:                       return SIZE_128B;
      endcase
   endfunction

   function automatic logic [7:0] size_to_bytes(input logic [2:0] size);
      return 8'd1 << norm_size(size);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_cmd_fifo
//  Description : Synchronous show-ahead command FIFO with occupancy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int WIDTH = 72
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] dout_o
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];

   // Storage array; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (w_push && !w_pop)      count_q <= count_q + 1'b1;
         else if (w_pop && !w_push) count_q <= count_q - 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_burst_resp_channel.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_resp_channel
//  Description : Slave-side AR/AW address channel. Queues address commands,
//                expands each burst into per-beat addresses, flags alignment
//                and 4KB-crossing violations and counts completed bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_resp_channel
   import memcopy_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [63:0] axi_addr,
   input  logic [7:0]  axi_len,
   input  logic        axi_valid,
   output logic        axi_ready,
   input  logic [2:0]  size,
   output logic [63:0] beat_addr,
   output logic        beat_last,
   output logic        beat_valid,
   input  logic        beat_ready,
   output logic        burst_done,
   output logic [31:0] burst_count,
   output logic        protocol_error,
   input  logic        clear_error
);

   state_e      state_q, state_d;
   cmd_t        cmd_q, cmd_d;
   logic [63:0] beat_addr_q, beat_addr_d;
   logic [7:0]  beats_left_q, beats_left_d;
   logic        burst_done_q, burst_done_d;
   logic [31:0] burst_count_q, burst_count_d;
   logic        perr_q, perr_d;

   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   cmd_t        w_fifo_dout;
   cmd_t        w_fifo_din;
   logic [2:0]  w_size;
   logic [7:0]  w_bytes;
   logic [63:0] w_stride;
   logic [16:0] w_span;
   logic        w_misalign;
   logic        w_cross;

   assign w_size     = norm_size(size);
   assign w_bytes    = size_to_bytes(size);
   assign w_stride   = {56'd0, w_bytes};
   assign w_push     = axi_valid && axi_ready;
   assign w_fifo_din = '{addr: axi_addr, len: axi_len};

   // Violation checks look only at the command being accepted this cycle
   assign w_misalign = (axi_addr[7:0] & (w_bytes - 8'd1)) != 8'd0;
   assign w_span     = ({9'd0, axi_len} + 17'd1) << w_size;
   assign w_cross    = ({5'd0, axi_addr[11:0]} + w_span) > KB4_BYTES;

   axi_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (w_push),
      .din_i   (w_fifo_din),
      .pop_i   (w_pop),
      .full_o  (w_full),
      .empty_o (w_empty),
      .dout_o  (w_fifo_dout)
   );

   assign axi_ready      = !w_full;
   assign beat_valid     = (state_q == BEAT);
   assign beat_last      = beat_valid && (beats_left_q == 8'd0);
   assign beat_addr      = beat_addr_q;
   assign burst_done     = burst_done_q;
   assign burst_count    = burst_count_q;
   assign protocol_error = perr_q;

   // Next-state: burst expansion FSM, completion counter and sticky error flag
   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      beat_addr_d   = beat_addr_q;
      beats_left_d  = beats_left_q;
      burst_done_d  = 1'b0;
      burst_count_d = burst_count_q;
      w_pop         = 1'b0;

      case (state_q)
         IDLE: begin
            // The popped entry is captured here since the FIFO head moves on
            if (!w_empty) begin
               w_pop   = 1'b1;
               cmd_d   = w_fifo_dout;
               state_d = LOAD;
            end
         end
         LOAD: begin
            beat_addr_d  = cmd_q.addr;
            beats_left_d = cmd_q.len;
            state_d      = BEAT;
         end
         BEAT: begin
            if (beat_ready) begin
               if (beats_left_q != 8'd0) begin
                  beat_addr_d  = beat_addr_q + w_stride;
                  beats_left_d = beats_left_q - 8'd1;
               end else begin
                  burst_done_d  = 1'b1;
                  burst_count_d = burst_count_q + 32'd1;
                  state_d       = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A new violation outranks a clear arriving in the same cycle
      if (w_push && (w_misalign || w_cross)) perr_d = 1'b1;
      else if (clear_error)                  perr_d = 1'b0;
      else                                   perr_d = perr_q;
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         cmd_q         <= '0;
         beat_addr_q   <= '0;
         beats_left_q  <= '0;
         burst_done_q  <= 1'b0;
         burst_count_q <= '0;
         perr_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         beat_addr_q   <= beat_addr_d;
         beats_left_q  <= beats_left_d;
         burst_done_q  <= burst_done_d;
         burst_count_q <= burst_count_d;
         perr_q        <= perr_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_resp_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_burst_resp_channel
//  Description : Directed self-checking bench for axi_burst_resp_channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_resp_channel;

   logic        clk = 1'b0;
   logic        resetn;
   logic [63:0] axi_addr;
   logic [7:0]  axi_len;
   logic        axi_valid;
   logic        axi_ready;
   logic [2:0]  size;
   logic [63:0] beat_addr;
   logic        beat_last;
   logic        beat_valid;
   logic        beat_ready;
   logic        burst_done;
   logic [31:0] burst_count;
   logic        protocol_error;
   logic        clear_error;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_cnt = 0;
   int          d0;
   logic [64:0] beats_q [$];
   logic        stall_prev = 1'b0;
   logic [63:0] prev_addr = '0;
   logic        prev_last = 1'b0;

   always #5 clk = ~clk;

   axi_burst_resp_channel #(
      .FIFO_DEPTH (4),
      .FIFO_AW    (2)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .axi_addr       (axi_addr),
      .axi_len        (axi_len),
      .axi_valid      (axi_valid),
      .axi_ready      (axi_ready),
      .size           (size),
      .beat_addr      (beat_addr),
      .beat_last      (beat_last),
      .beat_valid     (beat_valid),
      .beat_ready     (beat_ready),
      .burst_done     (burst_done),
      .burst_count    (burst_count),
      .protocol_error (protocol_error),
      .clear_error    (clear_error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Beat log, done-pulse counter and stall hold check, sampled mid-cycle
   always @(negedge clk) begin
      if (!resetn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_addr", beat_addr, prev_addr);
            chk("hold_last", 64'(beat_last), 64'(prev_last));
         end
         if (beat_valid && beat_ready) beats_q.push_back({beat_last, beat_addr});
         if (burst_done) done_cnt++;
         stall_prev = beat_valid && !beat_ready;
         prev_addr  = beat_addr;
         prev_last  = beat_last;
      end
   end

   task automatic push(input logic [63:0] a, input logic [7:0] l);
      axi_addr  = a;
      axi_len   = l;
      axi_valid = 1'b1;
      chk("push_ready", 64'(axi_ready), 64'd1);
      @(posedge clk); #1;
      axi_valid = 1'b0;
   endtask

   task automatic wait_count(input logic [31:0] tgt);
      int k = 0;
      while (burst_count != tgt && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      chk("burst_count", 64'(burst_count), 64'(tgt));
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!beat_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("valid_seen", 64'(beat_valid), 64'd1);
   endtask

   task automatic pulse_clear();
      clear_error = 1'b1;
      @(posedge clk); #1;
      clear_error = 1'b0;
   endtask

   task automatic check_beats(input string tag, input logic [63:0] base,
                              input logic [63:0] stride, input int n, input bit all_last);
      chk({tag, "_n"}, 64'(beats_q.size()), 64'(n));
      for (int i = 0; i < n && i < beats_q.size(); i++) begin
         chk({tag, "_addr"}, beats_q[i][63:0], base + stride * 64'(i));
         chk({tag, "_last"}, 64'(beats_q[i][64]), (all_last || i == n - 1) ? 64'd1 : 64'd0);
      end
      beats_q.delete();
   endtask

   initial begin
      resetn      = 1'b0;
      axi_addr    = '0;
      axi_len     = '0;
      axi_valid   = 1'b0;
      size        = 3'b110;
      beat_ready  = 1'b0;
      clear_error = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(axi_ready), 64'd1);
      chk("rst_valid", 64'(beat_valid), 64'd0);
      chk("rst_addr",  beat_addr, 64'd0);
      chk("rst_last",  64'(beat_last), 64'd0);
      chk("rst_done",  64'(burst_done), 64'd0);
      chk("rst_count", 64'(burst_count), 64'd0);
      chk("rst_perr",  64'(protocol_error), 64'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Basic burst with latency check
      beat_ready = 1'b1;
      d0 = done_cnt;
      push(64'h1000, 8'd3);
      chk("lat0", 64'(beat_valid), 64'd0);
      @(posedge clk); #1;
      chk("lat1", 64'(beat_valid), 64'd0);
      @(posedge clk); #1;
      chk("lat2", 64'(beat_valid), 64'd1);
      chk("lat2_addr", beat_addr, 64'h1000);
      wait_count(32'd1);
      @(posedge clk); #1;
      chk("basic_done", 64'(done_cnt - d0), 64'd1);
      chk("basic_perr", 64'(protocol_error), 64'd0);
      check_beats("basic", 64'h1000, 64'h40, 4, 1'b0);

      // FIFO full while the backend stalls
      beat_ready = 1'b0;
      push(64'h2000, 8'd0);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         axi_addr  = 64'h2040 + 64'h40 * 64'(i);
         axi_len   = 8'd0;
         axi_valid = 1'b1;
         if (i < 4) begin
            chk("fill_ready", 64'(axi_ready), 64'd1);
            @(posedge clk); #1;
         end else begin
            chk("full_ready", 64'(axi_ready), 64'd0);
         end
      end
      beat_ready = 1'b1;
      @(posedge clk); #1;
      chk("full_hold", 64'(axi_ready), 64'd0);
      @(posedge clk); #1;
      chk("ready_back", 64'(axi_ready), 64'd1);
      @(posedge clk); #1;
      axi_valid = 1'b0;
      wait_count(32'd7);
      @(posedge clk); #1;
      check_beats("full", 64'h2000, 64'h40, 6, 1'b1);

      // 4KB boundary: exact fit is legal, one beat further crosses
      push(64'h0F80, 8'd1);
      chk("kb4_exact_perr", 64'(protocol_error), 64'd0);
      wait_count(32'd8);
      @(posedge clk); #1;
      check_beats("kb4_exact", 64'h0F80, 64'h40, 2, 1'b0);
      push(64'h0FC0, 8'd1);
      chk("kb4_cross_perr", 64'(protocol_error), 64'd1);
      wait_count(32'd9);
      @(posedge clk); #1;
      check_beats("kb4_cross", 64'h0FC0, 64'h40, 2, 1'b0);
      pulse_clear();
      chk("clear_perr", 64'(protocol_error), 64'd0);

      // Misalignment, then set-beats-clear priority
      push(64'h1008, 8'd0);
      chk("misal_perr", 64'(protocol_error), 64'd1);
      wait_count(32'd10);
      @(posedge clk); #1;
      check_beats("misal", 64'h1008, 64'h40, 1, 1'b0);
      pulse_clear();
      chk("misal_clear", 64'(protocol_error), 64'd0);
      clear_error = 1'b1;
      push(64'h1008, 8'd0);
      clear_error = 1'b0;
      chk("prio_perr", 64'(protocol_error), 64'd1);
      wait_count(32'd11);
      @(posedge clk); #1;
      beats_q.delete();
      pulse_clear();
      chk("prio_clear", 64'(protocol_error), 64'd0);

      // Random backpressure on a 32-byte stride burst
      size = 3'b101;
      beat_ready = 1'b0;
      d0 = done_cnt;
      push(64'h3000, 8'd7);
      for (int k = 0; k < 300 && burst_count != 32'd12; k++) begin
         @(posedge clk); #1;
         beat_ready = 1'($urandom_range(0, 1));
      end
      chk("bp_count", 64'(burst_count), 64'd12);
      beat_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_done", 64'(done_cnt - d0), 64'd1);
      check_beats("bp", 64'h3000, 64'h20, 8, 1'b0);

      // Reset in the middle of a burst with two more queued
      size = 3'b110;
      beat_ready = 1'b0;
      push(64'h5000, 8'd3);
      push(64'h6000, 8'd3);
      push(64'h7000, 8'd3);
      wait_valid();
      beat_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      beat_ready = 1'b0;
      chk("pre_rst_addr", beat_addr, 64'h5080);
      #2;
      resetn = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(beat_valid), 64'd0);
      chk("mid_rst_addr",  beat_addr, 64'd0);
      chk("mid_rst_last",  64'(beat_last), 64'd0);
      chk("mid_rst_done",  64'(burst_done), 64'd0);
      chk("mid_rst_count", 64'(burst_count), 64'd0);
      chk("mid_rst_ready", 64'(axi_ready), 64'd1);
      beats_q.delete();
      @(posedge clk); #1;
      resetn = 1'b1;
      beat_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_beats", 64'(beats_q.size()), 64'd0);
      chk("post_rst_valid", 64'(beat_valid), 64'd0);
      push(64'h8000, 8'd0);
      wait_count(32'd1);
      @(posedge clk); #1;
      check_beats("post_rst", 64'h8000, 64'h40, 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
